// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and the round-robin pointer helper for the writeback scheduler.
package regfile_ctrl_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ZERO   = 0;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int PTR_W      = 3;

    // Pointer moves just past the requester that was served, wrapping at num_req.
    function automatic logic [PTR_W-1:0] rr_next_ptr(
        input logic [PTR_W-1:0] idx,
        input int               num_req
    );
        if (int'(idx) + 1 >= num_req) begin
            return '0;
        end
        return idx + PTR_W'(1);
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter; the pointer register lives in the parent.
module rr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] high_mask;
    logic [NUM_REQ-1:0] masked;

    // Prefer requesters at or above the pointer; otherwise wrap to the lowest.
    always_comb begin
        high_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            high_mask[i] = (i >= int'(ptr));
        end
        masked = req & high_mask;
        if (|masked) begin
            grant = masked & (~masked + NUM_REQ'(1));
        end else begin
            grant = req & (~req + NUM_REQ'(1));
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port arbiter with busy-bit scoreboard and hazard detection.
// Optional operand forwarding of the in-flight write when REGFILE_WB_BYPASS_EN is defined.
module regfile_wb_scheduler
    import regfile_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        REQ_VALID,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]        REQ_READY,
    output logic                      RF_WRITE_EN,
    output logic [ADDR_W-1:0]         RF_IN_ADDRESS,
    output logic [DATA_W-1:0]         RF_DATA_IN,
    input  logic                      ISSUE_VALID,
    input  logic [ADDR_W-1:0]         ISSUE_RD,
    input  logic [ADDR_W-1:0]         RS1_ADDRESS,
    input  logic [ADDR_W-1:0]         RS2_ADDRESS,
    output logic                      HAZARD,
    output logic                      ISSUE_ACCEPT,
    output logic [REG_COUNT-1:0]      BUSY_MASK
`ifdef REGFILE_WB_BYPASS_EN
    ,
    output logic                      FWD_SEL1,
    output logic                      FWD_SEL2,
    output logic [DATA_W-1:0]         FWD_DATA
`endif
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [PTR_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   grant;
    logic [PTR_W-1:0]     grant_idx;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;
    logic                 xfer;
    logic                 wr_go;
    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] set_vec;
    logic [REG_COUNT-1:0] clr_vec;
    logic                 haz_rs1;
    logic                 haz_rs2;
    logic                 haz_rd;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req  (REQ_VALID),
        .ptr  (rr_ptr),
        .grant(grant)
    );

    assign REQ_READY = RESET ? '0 : grant;

    always_comb begin
        grant_idx = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
                sel_addr  = REQ_ADDR[i*ADDR_W +: ADDR_W];
                sel_data  = REQ_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer  = |REQ_READY;
    assign wr_go = xfer && (sel_addr != ZERO_ADDR);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rr_ptr        <= '0;
            RF_WRITE_EN   <= 1'b0;
            RF_IN_ADDRESS <= '0;
            RF_DATA_IN    <= '0;
        end else begin
            RF_WRITE_EN <= wr_go;
            if (xfer) begin
                rr_ptr <= rr_next_ptr(grant_idx, NUM_REQ);
            end
            if (wr_go) begin
                RF_IN_ADDRESS <= sel_addr;
                RF_DATA_IN    <= sel_data;
            end
        end
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (ISSUE_ACCEPT && (ISSUE_RD != ZERO_ADDR)) begin
            set_vec = REG_COUNT'(1) << ISSUE_RD;
        end
        if (RF_WRITE_EN) begin
            clr_vec = REG_COUNT'(1) << RF_IN_ADDRESS;
        end
    end

    // Set is applied after clear so a new producer wins over a retiring one.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy_q <= '0;
        end else begin
            busy_q <= ((busy_q & ~clr_vec) | set_vec) & ~REG_COUNT'(1);
        end
    end

    assign BUSY_MASK = busy_q;

`ifdef REGFILE_WB_BYPASS_EN
    assign FWD_SEL1 = RF_WRITE_EN && (RF_IN_ADDRESS == RS1_ADDRESS)
                      && (RS1_ADDRESS != ZERO_ADDR);
    assign FWD_SEL2 = RF_WRITE_EN && (RF_IN_ADDRESS == RS2_ADDRESS)
                      && (RS2_ADDRESS != ZERO_ADDR);
    assign FWD_DATA = RF_DATA_IN;
    assign haz_rs1  = busy_q[RS1_ADDRESS] & ~FWD_SEL1;
    assign haz_rs2  = busy_q[RS2_ADDRESS] & ~FWD_SEL2;
`else
    assign haz_rs1  = busy_q[RS1_ADDRESS];
    assign haz_rs2  = busy_q[RS2_ADDRESS];
`endif

    assign haz_rd       = busy_q[ISSUE_RD];
    assign HAZARD       = ISSUE_VALID & (haz_rs1 | haz_rs2 | haz_rd);
    assign ISSUE_ACCEPT = ISSUE_VALID & ~HAZARD;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: vector table, corner sequences, random vs model.
module tb_regfile_wb_scheduler;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [N-1:0]    REQ_VALID;
    logic [N*AW-1:0] REQ_ADDR;
    logic [N*DW-1:0] REQ_DATA;
    logic [N-1:0]    REQ_READY;
    logic            RF_WRITE_EN;
    logic [AW-1:0]   RF_IN_ADDRESS;
    logic [DW-1:0]   RF_DATA_IN;
    logic            ISSUE_VALID;
    logic [AW-1:0]   ISSUE_RD;
    logic [AW-1:0]   RS1_ADDRESS;
    logic [AW-1:0]   RS2_ADDRESS;
    logic            HAZARD;
    logic            ISSUE_ACCEPT;
    logic [31:0]     BUSY_MASK;
`ifdef REGFILE_WB_BYPASS_EN
    logic            FWD_SEL1;
    logic            FWD_SEL2;
    logic [DW-1:0]   FWD_DATA;
`endif

    regfile_wb_scheduler #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .REQ_READY(REQ_READY),
        .RF_WRITE_EN(RF_WRITE_EN), .RF_IN_ADDRESS(RF_IN_ADDRESS),
        .RF_DATA_IN(RF_DATA_IN),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD),
        .RS1_ADDRESS(RS1_ADDRESS), .RS2_ADDRESS(RS2_ADDRESS),
        .HAZARD(HAZARD), .ISSUE_ACCEPT(ISSUE_ACCEPT), .BUSY_MASK(BUSY_MASK)
`ifdef REGFILE_WB_BYPASS_EN
        , .FWD_SEL1(FWD_SEL1), .FWD_SEL2(FWD_SEL2), .FWD_DATA(FWD_DATA)
`endif
    );

    always #10 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state: busy set, rr pointer, registered write port.
    bit [31:0] m_busy;
    int        m_ptr;
    bit        m_we;
    bit [4:0]  m_addr;
    bit [31:0] m_data;
    logic [N-1:0] last_ready;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       haz;
    } hvec_t;
    hvec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_ptr  = 0;
        m_we   = 0;
        m_addr = 0;
        m_data = 0;
    endtask

    // One clock: check all outputs against the model, then advance model and DUT.
    task automatic cycle();
        int  g;
        bit  t1, t2, haz, acc;
        bit  [4:0] ga;
        bit  [31:0] gd;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (g < 0 && REQ_VALID[i]) g = i;
        end
        t1 = m_busy[RS1_ADDRESS];
        t2 = m_busy[RS2_ADDRESS];
`ifdef REGFILE_WB_BYPASS_EN
        if (m_we && m_addr == RS1_ADDRESS && RS1_ADDRESS != 0) t1 = 0;
        if (m_we && m_addr == RS2_ADDRESS && RS2_ADDRESS != 0) t2 = 0;
        chk("fwd_sel1", 32'(FWD_SEL1),
            32'(m_we && m_addr == RS1_ADDRESS && RS1_ADDRESS != 0));
        chk("fwd_sel2", 32'(FWD_SEL2),
            32'(m_we && m_addr == RS2_ADDRESS && RS2_ADDRESS != 0));
        if (m_we) chk("fwd_data", FWD_DATA, m_data);
`endif
        haz = ISSUE_VALID && (t1 || t2 || m_busy[ISSUE_RD]);
        acc = ISSUE_VALID && !haz;
        chk("req_ready", 32'(REQ_READY), (g < 0) ? 0 : (32'd1 << g));
        chk("hazard", 32'(HAZARD), 32'(haz));
        chk("issue_accept", 32'(ISSUE_ACCEPT), 32'(acc));
        chk("busy_mask", BUSY_MASK, m_busy);
        chk("rf_we", 32'(RF_WRITE_EN), 32'(m_we));
        if (m_we) begin
            chk("rf_addr", 32'(RF_IN_ADDRESS), 32'(m_addr));
            chk("rf_data", RF_DATA_IN, m_data);
        end
        last_ready = REQ_READY;
        if (m_we) m_busy[m_addr] = 0;
        if (acc && ISSUE_RD != 0) m_busy[ISSUE_RD] = 1;
        m_we = 0;
        if (g >= 0) begin
            ga = REQ_ADDR[g*AW +: AW];
            gd = REQ_DATA[g*DW +: DW];
            m_ptr = (g + 1) % N;
            if (ga != 0) begin
                m_we   = 1;
                m_addr = ga;
                m_data = gd;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic wb(input int idx, input bit [4:0] a, input bit [31:0] d);
        bit done = 0;
        REQ_VALID[idx] = 1'b1;
        REQ_ADDR[idx*AW +: AW] = a;
        REQ_DATA[idx*DW +: DW] = d;
        for (int t = 0; t < 10 && !done; t++) begin
            cycle();
            if (last_ready[idx]) done = 1;
        end
        REQ_VALID[idx] = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL wb_timeout: requester %0d never granted", idx);
        end
    endtask

    task automatic set_issue(input bit v, input bit [4:0] rd, input bit [4:0] r1, input bit [4:0] r2);
        ISSUE_VALID = v;
        ISSUE_RD    = rd;
        RS1_ADDRESS = r1;
        RS2_ADDRESS = r2;
    endtask

    bit           pv[N];
    bit [4:0]     pa[N];
    bit [31:0]    pd[N];

    initial begin
        tbl[0] = '{1, 1, 5, 2, 1};
        tbl[1] = '{1, 1, 2, 9, 1};
        tbl[2] = '{1, 9, 0, 0, 1};
        tbl[3] = '{1, 0, 0, 0, 0};
        tbl[4] = '{0, 5, 5, 5, 0};
        tbl[5] = '{1, 3, 4, 6, 0};
        tbl[6] = '{1, 0, 5, 0, 1};
        tbl[7] = '{1, 31, 30, 29, 0};

        RESET = 1'b1;
        REQ_VALID = '1;
        REQ_ADDR = '0;
        REQ_DATA = '0;
        set_issue(0, 0, 0, 0);
        model_reset();
        #3;
        chk("rst_ready", 32'(REQ_READY), 0);
        chk("rst_we", 32'(RF_WRITE_EN), 0);
        chk("rst_addr", 32'(RF_IN_ADDRESS), 0);
        chk("rst_data", RF_DATA_IN, 0);
        chk("rst_busy", BUSY_MASK, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        REQ_VALID = '0;

        // Round robin with all requesters valid.
        REQ_VALID = 3'b111;
        for (int i = 0; i < N; i++) begin
            REQ_ADDR[i*AW +: AW] = AW'(i + 1);
            REQ_DATA[i*DW +: DW] = 32'h1000 + i;
        end
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rr_grant", 32'(last_ready), 32'd1 << (k % 3));
            chk("rr_we", 32'(RF_WRITE_EN), 1);
            chk("rr_addr", 32'(RF_IN_ADDRESS), (k % 3) + 1);
        end
        REQ_VALID = '0;
        cycle();

        // Register 0 write is accepted but never reaches the file.
        REQ_VALID = 3'b010;
        REQ_ADDR[AW +: AW] = 0;
        REQ_DATA[DW +: DW] = 32'hDEADBEEF;
        cycle();
        chk("r0_grant", 32'(last_ready), 32'b010);
        REQ_VALID = '0;
        chk("r0_we", 32'(RF_WRITE_EN), 0);
        cycle();
        chk("r0_we2", 32'(RF_WRITE_EN), 0);

        // Hazard vector table against busy = {5, 9}.
        set_issue(1, 5, 0, 0);
        cycle();
        set_issue(1, 9, 0, 0);
        cycle();
        set_issue(0, 0, 0, 0);
        chk("busy_5_9", BUSY_MASK, 32'h220);
        foreach (tbl[i]) begin
            set_issue(tbl[i].v, tbl[i].rd, tbl[i].rs1, tbl[i].rs2);
            #1;
            chk($sformatf("tbl%0d_haz", i), 32'(HAZARD), 32'(tbl[i].haz));
            chk($sformatf("tbl%0d_acc", i), 32'(ISSUE_ACCEPT), 32'(tbl[i].v && !tbl[i].haz));
        end
        set_issue(0, 0, 0, 0);
        cycle();

        // RAW on register 7.
        set_issue(1, 7, 0, 0);
        cycle();
        chk("raw_busy7", 32'(BUSY_MASK[7]), 1);
        set_issue(1, 0, 7, 0);
        cycle();
        chk("raw_haz", 32'(HAZARD), 1);
        wb(2, 7, 32'hA5A50007);
        chk("raw_we", 32'(RF_WRITE_EN), 1);
        chk("raw_addr", 32'(RF_IN_ADDRESS), 7);
`ifdef REGFILE_WB_BYPASS_EN
        chk("raw_haz_inflight", 32'(HAZARD), 0);
`else
        chk("raw_haz_inflight", 32'(HAZARD), 1);
`endif
        cycle();
        chk("raw_clear", 32'(HAZARD), 0);
        set_issue(0, 0, 0, 0);

        // Set and clear of register 9 on the same edge.
        wb(0, 5, 32'h55);
        wb(0, 9, 32'h99);
        wb(0, 9, 32'h999);
        set_issue(1, 9, 0, 0);
        cycle();
        set_issue(0, 0, 0, 0);
        chk("collide_busy9", 32'(BUSY_MASK[9]), 1);

`ifdef REGFILE_WB_BYPASS_EN
        set_issue(1, 4, 0, 0);
        cycle();
        set_issue(0, 0, 0, 0);
        wb(1, 4, 32'h12345678);
        set_issue(1, 0, 0, 4);
        #1;
        chk("byp_sel2", 32'(FWD_SEL2), 1);
        chk("byp_data", FWD_DATA, 32'h12345678);
        chk("byp_haz", 32'(HAZARD), 0);
        cycle();
        set_issue(0, 0, 0, 0);
`endif

        // Asynchronous reset in the middle of an in-flight write.
        set_issue(1, 5, 0, 0);
        cycle();
        set_issue(0, 0, 0, 0);
        wb(1, 9, 32'hCAFE0009);
        REQ_VALID = 3'b111;
        #3;
        RESET = 1'b1;
        #1;
        chk("arst_we", 32'(RF_WRITE_EN), 0);
        chk("arst_addr", 32'(RF_IN_ADDRESS), 0);
        chk("arst_data", RF_DATA_IN, 0);
        chk("arst_busy", BUSY_MASK, 0);
        chk("arst_ready", 32'(REQ_READY), 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        REQ_VALID = '0;
        model_reset();

        // Random traffic against the model.
        for (int i = 0; i < N; i++) pv[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && ($urandom % 3 == 0)) begin
                    pv[i] = 1;
                    pa[i] = 5'($urandom_range(0, 7));
                    pd[i] = $urandom;
                end
                REQ_VALID[i] = pv[i];
                REQ_ADDR[i*AW +: AW] = pa[i];
                REQ_DATA[i*DW +: DW] = pd[i];
            end
            set_issue(1'($urandom % 2), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            cycle();
            for (int i = 0; i < N; i++) begin
                if (last_ready[i]) pv[i] = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
